// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch sequencer between the instruction ROM and the execution stage
//
// Purpose:
//   Steps the instruction ROM, waits ROM_SETTLE clocks for its outputs to
//   settle, latches instruction + operand into a valid/ready issue slot and
//   advances the ROM only after the execution stage accepts. An instruction
//   with its top bit set is the HALT encoding: it is latched but never issued,
//   and the sequencer parks in HALTED until reset.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    begin fetching (sampled only in IDLE)
//   rom_instr, rom_data      ROM instruction / operand inputs
//   rom_step                 registered one-clock ROM advance strobe
//   issue_valid/issue_ready  issue slot handshake
//   issue_instr, issue_data  latched instruction / operand
//   pc                       steps issued since reset (wraps at 8 bits)
//   busy                     sequencer active (not IDLE, not HALTED)
//   halted                   HALT fetched, sticky until reset

module instr_fetch_ctrl #(
    parameter int ROM_SETTLE = 1,
    parameter int INSTR_W    = 9,
    parameter int DATA_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic               rom_step,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [DATA_W-1:0]  issue_data,
    output logic [7:0]         pc,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ISSUE  = 3'd2,
        S_STEP   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(ROM_SETTLE);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [INSTR_W-1:0] issue_instr_q, issue_instr_d;
    logic [DATA_W-1:0]  issue_data_q, issue_data_d;
    logic [7:0]         pc_q, pc_d;
    logic               rom_step_q, rom_step_d;
    logic               issue_valid_q, issue_valid_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        issue_instr_d = issue_instr_q;
        issue_data_d  = issue_data_q;
        pc_d          = pc_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                // Sample on the last settle clock so SETTLE spans exactly
                // ROM_SETTLE clocks; <= 1 also guards an out-of-range 0.
                if (cnt_q <= 4'd1) begin
                    issue_instr_d = rom_instr;
                    issue_data_d  = rom_data;
                    state_d       = rom_instr[INSTR_W-1] ? S_HALTED : S_ISSUE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    state_d = S_STEP;
                    pc_d    = pc_q + 8'd1;
                end
            end
            S_STEP: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state and never glitch.
        rom_step_d    = (state_d == S_STEP);
        issue_valid_d = (state_d == S_ISSUE);
        halted_d      = (state_d == S_HALTED);
        busy_d        = (state_d == S_SETTLE) || (state_d == S_ISSUE) || (state_d == S_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            issue_instr_q <= '0;
            issue_data_q  <= '0;
            pc_q          <= '0;
            rom_step_q    <= 1'b0;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            issue_instr_q <= issue_instr_d;
            issue_data_q  <= issue_data_d;
            pc_q          <= pc_d;
            rom_step_q    <= rom_step_d;
            issue_valid_q <= issue_valid_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign rom_step    = rom_step_q;
    assign issue_valid = issue_valid_q;
    assign issue_instr = issue_instr_q;
    assign issue_data  = issue_data_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - scoreboard testbench for instr_fetch_ctrl

module tb_instr_fetch_ctrl;

    localparam int         SET    = 3;
    localparam logic [8:0] HALT_W = 9'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- main DUT, ROM_SETTLE = 3 ----------------
    logic        rst_n = 1'b0, start = 1'b0, issue_ready = 1'b0;
    logic [8:0]  rom_instr, issue_instr;
    logic [15:0] rom_data, issue_data;
    logic [7:0]  pc;
    logic        rom_step, issue_valid, busy, halted;

    instr_fetch_ctrl #(.ROM_SETTLE(SET), .INSTR_W(9), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_instr(rom_instr), .rom_data(rom_data), .rom_step(rom_step),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_data(issue_data),
        .pc(pc), .busy(busy), .halted(halted)
    );

    // ROM model: address advances on each step strobe; the bench realigns it on reset.
    logic [24:0] rom_mem [0:511];
    logic [8:0]  rom_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rom_addr <= '0;
        else if (rom_step) rom_addr <= rom_addr + 9'd1;
    end
    assign rom_instr = rom_mem[rom_addr][24:16];
    assign rom_data  = rom_mem[rom_addr][15:0];

    // ---------------- small DUT, ROM_SETTLE = 1 ----------------
    logic        rst1_n = 1'b0, start1 = 1'b0, ready1 = 1'b0;
    logic [8:0]  rom1_instr = 9'h012, instr1;
    logic [15:0] rom1_data = 16'hBEEF, data1;
    logic [7:0]  pc1;
    logic        step1, valid1, busy1, halted1;
    int          step1_cnt = 0;

    instr_fetch_ctrl #(.ROM_SETTLE(1), .INSTR_W(9), .DATA_W(16)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1),
        .rom_instr(rom1_instr), .rom_data(rom1_data), .rom_step(step1),
        .issue_valid(valid1), .issue_ready(ready1),
        .issue_instr(instr1), .issue_data(data1),
        .pc(pc1), .busy(busy1), .halted(halted1)
    );
    always @(posedge step1) step1_cnt++;

    // ---------------- scoreboard ----------------
    logic [24:0] exp_q[$];
    int          accepted = 0;
    int          cyc = 0;
    int          last_hs = -1;
    bit          stream_mode = 0;
    bit          prev_hold = 0, prev_hs = 0;
    logic [8:0]  prev_instr;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        logic [24:0] w;
        bit hs;
        cyc++;
        if (!rst_n) begin
            accepted  = 0;
            last_hs   = -1;
            prev_hold = 0;
            prev_hs   = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(issue_valid), 64'd1);
                chk("hold_instr", 64'(issue_instr), 64'(prev_instr));
                chk("hold_data", 64'(issue_data), 64'(prev_data));
            end
            if (rom_step || prev_hs)
                chk("step_follows_handshake", 64'(rom_step), 64'(prev_hs));
            hs = issue_valid && issue_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue actual=%0h expected=none", issue_instr);
                end else begin
                    w = exp_q.pop_front();
                    chk("issue_instr", 64'(issue_instr), 64'(w[24:16]));
                    chk("issue_data", 64'(issue_data), 64'(w[15:0]));
                end
                chk("pc_at_handshake", 64'(pc), 64'(accepted % 256));
                if (stream_mode && last_hs >= 0)
                    chk("stream_interval", 64'(cyc - last_hs), 64'(SET + 2));
                accepted++;
                last_hs = cyc;
            end
            prev_hold  = issue_valid && !issue_ready;
            prev_hs    = hs;
            prev_instr = issue_instr;
            prev_data  = issue_data;
        end
    end

    // ---------------- reference model and stimulus helpers ----------------
    // Program: n_norm ordinary words followed by a HALT word.
    task automatic fill_rom(input int n_norm);
        for (int k = 0; k < n_norm; k++)
            rom_mem[k] = {1'b0, 8'($urandom), 8'(k), 8'($urandom)};
        rom_mem[n_norm] = {HALT_W, 16'($urandom)};
    endtask

    // Expected issue stream: every word from address 0 up to the first HALT.
    task automatic build_expect(output int n);
        n = 0;
        exp_q.delete();
        while (rom_mem[n][24] == 1'b0) begin
            exp_q.push_back(rom_mem[n]);
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        issue_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        chk("halt_reached", 64'(halted), 64'd1);
    endtask

    task automatic check_halted(input int n);
        @(negedge clk);
        chk("halted_flag", 64'(halted), 64'd1);
        chk("halted_busy", 64'(busy), 64'd0);
        chk("halted_valid", 64'(issue_valid), 64'd0);
        chk("halted_step", 64'(rom_step), 64'd0);
        chk("halted_pc", 64'(pc), 64'(n % 256));
        chk("halted_instr", 64'(issue_instr), 64'(HALT_W));
        chk("halted_data", 64'(issue_data), 64'(rom_mem[n][15:0]));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic restart_ignored(input int n);
        pulse_start();
        repeat (SET + 4) @(negedge clk);
        check_halted(n);
    endtask

    task automatic random_ready(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1 issue_ready = ($urandom_range(0, 3) != 0);
            if (halted) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // ---- ROM_SETTLE=1 instance: reset, first fetch, backpressure, async reset ----
        repeat (2) @(negedge clk);
        chk("t1_reset_outputs", 64'({step1, valid1, instr1, data1, pc1, busy1, halted1}), 64'd0);
        @(posedge clk);
        #1 rst1_n = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        chk("t2_valid_after_edge0", 64'(valid1), 64'd0);
        chk("t2_busy_after_edge0", 64'(busy1), 64'd1);
        @(negedge clk);
        chk("t2_valid", 64'(valid1), 64'd1);
        chk("t2_instr", 64'(instr1), 64'h012);
        chk("t2_data", 64'(data1), 64'hBEEF);
        chk("t2_pc", 64'(pc1), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold", 64'({valid1, step1, instr1, data1}), 64'({1'b1, 1'b0, 9'h012, 16'hBEEF}));
        end
        @(posedge clk);
        #1 ready1 = 1'b1;
        @(posedge clk);
        #1 ready1 = 1'b0;
        @(negedge clk);
        chk("t3_step", 64'({step1, valid1}), 64'({1'b1, 1'b0}));
        chk("t3_pc", 64'(pc1), 64'd1);
        @(negedge clk);
        chk("t3_step_one_clock", 64'(step1), 64'd0);
        @(negedge clk);
        chk("t1_in_issue", 64'(valid1), 64'd1);
        #2 rst1_n = 1'b0;
        #1;
        chk("t1_async_reset", 64'({step1, valid1, instr1, data1, pc1, busy1, halted1}), 64'd0);
        chk("t3_single_step_pulse", 64'(step1_cnt), 64'd1);

        // ---- main: streaming with ready high, then halt ----
        fill_rom(5);
        do_reset();
        build_expect(n);
        issue_ready = 1'b1;
        stream_mode = 1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= SET; k++) begin
            @(negedge clk);
            chk("first_issue_latency", 64'(issue_valid), 64'(k == SET));
        end
        wait_halt(200);
        stream_mode = 0;
        check_halted(n);
        restart_ignored(n);

        // ---- main: backpressure, then HALT as the third word ----
        fill_rom(2);
        do_reset();
        build_expect(n);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (issue_valid) break;
        end
        chk("bp_valid_seen", 64'(issue_valid), 64'd1);
        repeat (10) @(negedge clk);
        chk("bp_pc_still_zero", 64'(pc), 64'd0);
        @(posedge clk);
        #1 issue_ready = 1'b1;
        @(posedge clk);
        #1 issue_ready = 1'b0;
        @(negedge clk);
        chk("bp_step", 64'(rom_step), 64'd1);
        chk("bp_pc_one", 64'(pc), 64'd1);
        random_ready(300);
        wait_halt(100);
        check_halted(n);
        restart_ignored(n);

        // ---- main: random backpressure ----
        fill_rom(40);
        do_reset();
        build_expect(n);
        pulse_start();
        random_ready(2000);
        wait_halt(100);
        check_halted(n);

        // ---- main: pc wrap while streaming ----
        fill_rom(300);
        do_reset();
        build_expect(n);
        issue_ready = 1'b1;
        stream_mode = 1;
        pulse_start();
        wait_halt(2000);
        stream_mode = 0;
        check_halted(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
